// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronizes and glitch-filters the A/B
// channels, decodes Gray-code transitions into step/up_down pulses for a
// downstream counter, keeps a local 8-bit position and flags illegal jumps.
module quad_decoder #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       clr_err,
  output logic       step,
  output logic       up_down,
  output logic [7:0] pos,
  output logic       err
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  // Bit 1 carries channel A, bit 0 carries channel B throughout.
  logic [1:0]            sync_p0;
  logic [1:0]            sync_p1;
  logic [1:0]            filt_p2;
  logic [1:0][CNT_W-1:0] cnt_p2;
  logic [1:0]            prev;
  logic [0:0]            state;
  logic [1:0]            settle;

  logic [1:0] diff;
  logic       chg_one;
  logic       chg_both;
  logic       dir_up;

  // Position within the up sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Position update wraps naturally modulo 256 in both directions.
  function automatic logic [7:0] pos_next(input logic [7:0] p, input logic up);
    return up ? (p + 8'd1) : (p - 8'd1);
  endfunction

  // Two-flop synchronizers for the asynchronous encoder inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= {enc_a, enc_b};
      sync_p1 <= sync_p0;
    end
  end

  // Per-channel stability filter: a new level is accepted only after it has
  // differed from the filtered level for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_p2 <= 2'b00;
      cnt_p2  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != filt_p2[i]) begin
          if (cnt_p2[i] == CNT_LAST) begin
            filt_p2[i] <= sync_p1[i];
            cnt_p2[i]  <= '0;
          end else begin
            cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
          end
        end else begin
          cnt_p2[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    diff     = filt_p2 ^ prev;
    chg_one  = (state == ST_TRACK) && ((diff == 2'b01) || (diff == 2'b10));
    chg_both = (state == ST_TRACK) && (diff == 2'b11);
    dir_up   = ((gray_idx(filt_p2) - gray_idx(prev)) == 2'd1);
  end

  // INIT waits for the synchronizers to fill and the filters to settle on the
  // encoder's current level so that adopting it never looks like a jump;
  // TRACK turns each filtered change into a step or an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      settle  <= 2'd0;
      prev    <= 2'b00;
      step    <= 1'b0;
      up_down <= 1'b1;
      pos     <= 8'h00;
      err     <= 1'b0;
    end else begin
      step <= 1'b0;
      prev <= filt_p2;
      case (state)
        ST_INIT: begin
          if (settle != 2'd2) begin
            settle <= settle + 2'd1;
          end else if (sync_p1 == filt_p2) begin
            state <= ST_TRACK;
          end
        end
        default: begin
          if (chg_one) begin
            step    <= 1'b1;
            up_down <= dir_up;
            pos     <= pos_next(pos, dir_up);
          end
        end
      endcase
      if (chg_both) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

  localparam int FL = 3;
  localparam int NR = 3000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enc_a;
  logic       enc_b;
  logic       clr_err;
  logic       step;
  logic       up_down;
  logic [7:0] pos;
  logic       err;

  int checks = 0;
  int failures = 0;

  quad_decoder #(.FILTER_LEN(FL)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .clr_err(clr_err),
    .step   (step),
    .up_down(up_down),
    .pos    (pos),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;
    int         n;
    logic       clr;
    int         steps;
    logic [7:0] pos;
    logic       ud;
    logic       err;
  } vec_t;

  vec_t tbl [13];

  // Reference model state for the randomized phase
  logic [1:0] hist [NR];
  logic [1:0] f_cur, f_old;
  logic       m_step, m_ud, m_err;
  logic [7:0] m_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, output int steps);
    steps = 0;
    repeat (n) begin
      tick();
      if (step === 1'b1) steps++;
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    clr_err = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Index of a code in the up sequence 00,01,11,10
  function automatic int seq_idx(input logic [1:0] ab);
    logic [1:0] codes [4];
    codes = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int k = 0; k < 4; k++) if (codes[k] == ab) return k;
    return 0;
  endfunction

  // True when the synchronized samples seen at the last FL edges before
  // edge t all differ from lvl on channel c (raw applied at edge t-2 is what
  // the filter sees at edge t).
  function automatic bit window_differs(input int t, input int c, input logic lvl);
    logic v;
    for (int j = 2; j <= FL + 1; j++) begin
      v = (t - j < 0) ? 1'b0 : hist[t - j][c];
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input int t, input logic clr);
    logic [1:0] d;
    logic [1:0] f_new;
    int delta;
    d = f_cur ^ f_old;
    m_step = 1'b0;
    if (d == 2'b01 || d == 2'b10) begin
      delta = (seq_idx(f_cur) - seq_idx(f_old) + 4) % 4;
      m_step = 1'b1;
      m_ud = (delta == 1);
      m_pos = (delta == 1) ? m_pos + 8'd1 : m_pos - 8'd1;
    end
    if (d == 2'b11) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    f_new = f_cur;
    for (int c = 0; c < 2; c++)
      if (window_differs(t, c, f_cur[c])) f_new[c] = ~f_cur[c];
    f_old = f_cur;
    f_cur = f_new;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int lat;
    logic [1:0] ab;
    logic clrv;

    reset_n = 1'b1;
    enc_a = 1'b1;
    enc_b = 1'b1;
    clr_err = 1'b0;

    // Reset takes effect before any clock edge
    #3 reset_n = 1'b0;
    #1;
    chk("rst_step", step, 1'b0);
    chk("rst_up_down", up_down, 1'b1);
    chk("rst_pos", pos, 8'h00);
    chk("rst_err", err, 1'b0);

    // Release with encoder at 11: level adopted silently
    tick();
    tick();
    reset_n = 1'b1;
    hold(20, s);
    chk("init11_steps", s, 0);
    chk("init11_err", err, 1'b0);
    chk("init11_pos", pos, 8'h00);

    // Table-driven sequence from 00
    tbl[0]  = '{2'b01, 8, 1'b0, 1, 8'h01, 1'b1, 1'b0};
    tbl[1]  = '{2'b11, 8, 1'b0, 1, 8'h02, 1'b1, 1'b0};
    tbl[2]  = '{2'b10, 8, 1'b0, 1, 8'h03, 1'b1, 1'b0};
    tbl[3]  = '{2'b00, 8, 1'b0, 1, 8'h04, 1'b1, 1'b0};
    tbl[4]  = '{2'b10, 8, 1'b0, 1, 8'h03, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 8, 1'b0, 1, 8'h02, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 8, 1'b0, 1, 8'h01, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 8, 1'b0, 1, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{2'b10, 8, 1'b0, 1, 8'hFF, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 8, 1'b0, 1, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{2'b11, 8, 1'b0, 0, 8'h00, 1'b1, 1'b1};
    tbl[11] = '{2'b11, 1, 1'b1, 0, 8'h00, 1'b1, 1'b0};
    tbl[12] = '{2'b01, 8, 1'b0, 1, 8'hFF, 1'b0, 1'b0};

    do_reset(1'b0, 1'b0);
    hold(20, s);
    chk("init00_steps", s, 0);
    for (int i = 0; i < 13; i++) begin
      enc_a = tbl[i].ab[1];
      enc_b = tbl[i].ab[0];
      clr_err = tbl[i].clr;
      hold(tbl[i].n, s);
      clr_err = 1'b0;
      chk($sformatf("vec%0d_steps", i), s, tbl[i].steps);
      chk($sformatf("vec%0d_pos", i), pos, tbl[i].pos);
      chk($sformatf("vec%0d_up_down", i), up_down, tbl[i].ud);
      chk($sformatf("vec%0d_err", i), err, tbl[i].err);
    end

    // Latency 01 -> 11, with wrap FF -> 00
    enc_a = 1'b1;
    enc_b = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, FL + 3);
    chk("wrap_up_pos", pos, 8'h00);
    chk("wrap_up_dir", up_down, 1'b1);
    tick();
    chk("step_one_cycle", step, 1'b0);
    hold(3, s);
    chk("no_extra_step", s, 0);

    // Walk to 00 (pos 2), then a 2-cycle glitch on A
    enc_a = 1'b1; enc_b = 1'b0;
    hold(8, s);
    enc_a = 1'b0; enc_b = 1'b0;
    hold(8, s);
    chk("pre_glitch_pos", pos, 8'h02);
    enc_a = 1'b1;
    hold(2, s);
    enc_a = 1'b0;
    hold(10, lat);
    chk("glitch_steps", s + lat, 0);
    chk("glitch_pos", pos, 8'h02);
    chk("glitch_err", err, 1'b0);

    // Reset two cycles into a 00 -> 01 change
    enc_b = 1'b1;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_pos", pos, 8'h00);
    chk("midreset_step", step, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    hold(20, s);
    chk("after_midreset_steps", s, 0);
    chk("after_midreset_pos", pos, 8'h00);
    chk("after_midreset_err", err, 1'b0);
    enc_a = 1'b1;
    hold(8, s);
    chk("post_reset_up_steps", s, 1);
    chk("post_reset_up_pos", pos, 8'h01);
    chk("post_reset_up_dir", up_down, 1'b1);

    // Randomized run against the reference model
    do_reset(1'b0, 1'b0);
    hold(15, s);
    f_cur = 2'b00;
    f_old = 2'b00;
    m_step = 1'b0;
    m_ud = 1'b1;
    m_pos = 8'h00;
    m_err = 1'b0;
    ab = 2'b00;
    for (int t = 0; t < NR; t++) begin
      if ($urandom_range(3) == 0) ab[1] = ~ab[1];
      if ($urandom_range(3) == 0) ab[0] = ~ab[0];
      clrv = ($urandom_range(31) == 0);
      enc_a = ab[1];
      enc_b = ab[0];
      clr_err = clrv;
      hist[t] = ab;
      tick();
      model_edge(t, clrv);
      chk($sformatf("rnd%0d_step", t), step, m_step);
      chk($sformatf("rnd%0d_up_down", t), up_down, m_ud);
      chk($sformatf("rnd%0d_pos", t), pos, m_pos);
      chk($sformatf("rnd%0d_err", t), err, m_err);
    end
    clr_err = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
